// File: rtl/byte_lane_dly_seq.sv
// Shadow-register delay sequencer for DDR3 byte lanes: keeps every IODELAY value,
// sweeps them onto the shared load bus with per-lane strobes, then issues a broadcast set.
module byte_lane_dly_seq #(
  parameter int NUM_LANES  = 2,
  parameter bit DIRTY_ONLY = 1'b1,
  parameter int SET_GAP    = 2,
  localparam int LB        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [LB+4:0]        wr_addr,
  input  logic [7:0]           wr_data,
  input  logic [LB+4:0]        rd_addr,
  output logic [7:0]           rd_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           dly_data,
  output logic [4:0]           dly_addr,
  output logic [NUM_LANES-1:0] ld_delay,
  output logic                 set
);

  localparam int S  = 19 * NUM_LANES;
  localparam int SW = $clog2(S + 1);
  localparam logic [SW-1:0] SLOT_END   = SW'(S);
  localparam logic [SW-1:0] LANE_SLOTS = SW'(19);
  localparam logic [3:0]    GAP_LAST   = 4'(SET_GAP);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_GAP  = 3'd2,
    ST_SET  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic addr_ok(input logic [LB+4:0] a);
    logic [4:0] a5;
    a5 = a[4:0];
    return (int'(a[LB+4:5]) < NUM_LANES) &&
           ((a5 <= 5'd9) || ((a5 >= 5'd16) && (a5 <= 5'd24)));
  endfunction

  // Slots 0..9 map directly; input delays 16..24 pack into slots 10..18.
  function automatic logic [SW-1:0] slot_of(input logic [LB+4:0] a);
    logic [4:0] k;
    if (a[4:0] <= 5'd9) k = a[4:0];
    else                k = a[4:0] - 5'd6;
    return SW'(a[LB+4:5]) * LANE_SLOTS + SW'(k);
  endfunction

  logic [7:0]           shadow [S];
  logic [S-1:0]         dirty;
  state_t               state, state_n;
  logic [SW-1:0]        ptr, ptr_n;
  logic [LB-1:0]        lane_cnt, lane_n;
  logic [4:0]           k_cnt, k_n;
  logic [3:0]           gap_cnt, gap_n;
  logic                 busy_n, done_n, set_n, step, issue;
  logic [NUM_LANES-1:0] ld_n;
  logic [7:0]           dly_data_n;
  logic [4:0]           dly_addr_n, scan_addr;
  logic                 wr_hit, rd_hit;
  logic [SW-1:0]        wr_slot, rd_slot;

  assign wr_hit  = wr_en && addr_ok(wr_addr);
  assign wr_slot = slot_of(wr_addr);
  assign rd_hit  = addr_ok(rd_addr);
  assign rd_slot = slot_of(rd_addr);

  // Sweep sequencing: ptr/lane_cnt/k_cnt name the slot issued at the coming edge.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    lane_n     = lane_cnt;
    k_n        = k_cnt;
    gap_n      = gap_cnt;
    busy_n     = busy;
    done_n     = 1'b0;
    set_n      = 1'b0;
    ld_n       = '0;
    dly_data_n = dly_data;
    dly_addr_n = dly_addr;
    step       = 1'b0;
    issue      = 1'b0;
    if (k_cnt <= 5'd9) scan_addr = k_cnt;
    else               scan_addr = k_cnt + 5'd6;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_SCAN;
          busy_n  = 1'b1;
          step    = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (ptr == SLOT_END) begin
          state_n = ST_GAP;
          gap_n   = 4'd1;
          ptr_n   = '0;
          lane_n  = '0;
          k_n     = 5'd0;
        end else begin
          step = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = ST_SET;
          set_n   = 1'b1;
        end else begin
          gap_n = gap_cnt + 4'd1;
        end
      end
      ST_SET: begin
        state_n = ST_DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase

    if (step) begin
      ptr_n = ptr + {{(SW-1){1'b0}}, 1'b1};
      if (k_cnt == 5'd18) begin
        k_n    = 5'd0;
        lane_n = lane_cnt + {{(LB-1){1'b0}}, 1'b1};
      end else begin
        k_n = k_cnt + 5'd1;
      end
      if (!DIRTY_ONLY || dirty[ptr]) begin
        issue      = 1'b1;
        dly_data_n = shadow[ptr];
        dly_addr_n = scan_addr;
        for (int i = 0; i < NUM_LANES; i++) begin
          ld_n[i] = (lane_cnt == LB'(i));
        end
      end else begin
        issue = 1'b0;
      end
    end else begin
      step = 1'b0;
    end
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      lane_cnt <= '0;
      k_cnt    <= 5'd0;
      gap_cnt  <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      set      <= 1'b0;
      ld_delay <= '0;
      dly_data <= 8'd0;
      dly_addr <= 5'd0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      lane_cnt <= lane_n;
      k_cnt    <= k_n;
      gap_cnt  <= gap_n;
      busy     <= busy_n;
      done     <= done_n;
      set      <= set_n;
      ld_delay <= ld_n;
      dly_data <= dly_data_n;
      dly_addr <= dly_addr_n;
    end
  end

  // Shadow storage, dirty tracking and readback; a same-cycle host write re-marks the slot dirty.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        shadow[i] <= 8'd0;
      end
      dirty   <= '1;
      rd_data <= 8'd0;
    end else begin
      if (issue) begin
        dirty[ptr] <= 1'b0;
      end
      if (wr_hit) begin
        shadow[wr_slot] <= wr_data;
        dirty[wr_slot]  <= 1'b1;
      end
      rd_data <= rd_hit ? shadow[rd_slot] : 8'd0;
    end
  end

endmodule
